// File: rtl/line_loader.sv
// Writer side of the character-pair line memory: packs an lhs/rhs byte stream into
// 16-bit words and commits a {len, start} pointer entry at each end-of-line.
module line_loader #(
  parameter logic [7:0] PAD_CHAR  = 8'h20,
  parameter int         MEM_WORDS = 1024,
  parameter int         MAX_LINES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [15:0] mem_din,
  output logic        ptr_we,
  output logic [7:0]  ptr_addr,
  output logic [19:0] ptr_din,
  output logic [8:0]  lines_loaded,
  output logic        overflow
);

  // state  | meaning
  // S_LHS  | waiting for the lhs byte of a pair
  // S_RHS  | lhs latched, waiting for the rhs byte
  // S_PTR  | one-cycle pointer commit, input stalled
  // S_FULL | memory or table exhausted, bytes discarded until restart
  typedef enum logic [1:0] {S_LHS, S_RHS, S_PTR, S_FULL} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_lhs;
  logic [10:0] r_next_addr;
  logic [10:0] r_word_cnt;
  logic [9:0]  r_line_start;
  logic [8:0]  r_line_idx;

  logic        w_accept;
  logic        w_word_due;
  logic        w_word_we;
  logic [15:0] w_word;
  logic        w_ptr_we;
  logic        w_set_ovf;
  logic        w_mem_room;
  logic        w_table_room;

  assign in_ready     = (r_state != S_PTR) && !rst && !clear;
  assign w_accept     = in_valid && in_ready;
  assign w_mem_room   = r_next_addr < 11'(MEM_WORDS);
  assign w_table_room = r_line_idx < 9'(MAX_LINES);
  assign lines_loaded = r_line_idx;

  always_comb begin
    w_state_nxt = r_state;
    w_word_due  = 1'b0;
    w_word      = {r_lhs, in_data};
    w_ptr_we    = 1'b0;
    w_set_ovf   = 1'b0;
    case (r_state)
      S_LHS: begin
        if (w_accept) begin
          if (in_last) begin
            w_word_due  = 1'b1;
            w_word      = {in_data, PAD_CHAR};
            w_state_nxt = S_PTR;
          end else begin
            w_state_nxt = S_RHS;
          end
        end
      end
      S_RHS: begin
        if (w_accept) begin
          w_word_due  = 1'b1;
          w_word      = {r_lhs, in_data};
          w_state_nxt = in_last ? S_PTR : S_LHS;
        end
      end
      S_PTR: begin
        if (w_table_room) begin
          w_ptr_we    = 1'b1;
          w_state_nxt = S_LHS;
        end else begin
          w_set_ovf   = 1'b1;
          w_state_nxt = S_FULL;
        end
      end
      default: w_state_nxt = S_FULL;
    endcase
    // A word with nowhere to go abandons the partial line entirely.
    if (w_word_due && !w_mem_room) begin
      w_set_ovf   = 1'b1;
      w_state_nxt = S_FULL;
    end
  end

  assign w_word_we = w_word_due && w_mem_room;

  always_ff @(posedge clk) begin
    if (rst || clear) r_state <= S_LHS;
    else              r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      ptr_we       <= 1'b0;
      ptr_addr     <= '0;
      ptr_din      <= '0;
      overflow     <= 1'b0;
      r_lhs        <= '0;
      r_next_addr  <= '0;
      r_word_cnt   <= '0;
      r_line_start <= '0;
      r_line_idx   <= '0;
    end else begin
      mem_we <= w_word_we;
      ptr_we <= w_ptr_we;
      if (w_accept && r_state == S_LHS) r_lhs <= in_data;
      if (w_word_we) begin
        mem_addr    <= r_next_addr[9:0];
        mem_din     <= w_word;
        r_next_addr <= r_next_addr + 11'd1;
        r_word_cnt  <= r_word_cnt + 11'd1;
      end
      // len is stored as pairs-minus-one since the reader walks start..start+len inclusive
      if (w_ptr_we) begin
        ptr_addr     <= r_line_idx[7:0];
        ptr_din      <= {10'(r_word_cnt - 11'd1), r_line_start};
        r_line_idx   <= r_line_idx + 9'd1;
        r_line_start <= r_next_addr[9:0];
        r_word_cnt   <= '0;
      end
      if (w_set_ovf) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_line_loader.sv
// Bench for line_loader: a byte/line-level reference model predicts every output
// each cycle; literal checks pin the model on the hand-worked scenarios.
module tb_line_loader;

  localparam logic [7:0] PAD = 8'h20;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_din;
  logic        ptr_we;
  logic [7:0]  ptr_addr;
  logic [19:0] ptr_din;
  logic [8:0]  lines_loaded;
  logic        overflow;

  line_loader dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .ptr_we(ptr_we), .ptr_addr(ptr_addr), .ptr_din(ptr_din),
    .lines_loaded(lines_loaded), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string name);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes of the unfinished pair, words and lines committed so far.
  logic [7:0]  m_pend[$];
  int          m_words, m_lines, m_line_start;
  bit          m_full, m_ptr_pending;
  logic        e_mem_we, e_ptr_we, e_ovf;
  logic [9:0]  e_mem_addr;
  logic [15:0] e_mem_din;
  logic [7:0]  e_ptr_addr;
  logic [19:0] e_ptr_din;

  always @(posedge clk) begin
    logic [15:0] word;
    logic [9:0]  len;
    e_mem_we = 1'b0;
    e_ptr_we = 1'b0;
    if (rst || clear) begin
      m_pend.delete();
      m_words = 0; m_lines = 0; m_line_start = 0;
      m_full = 0; m_ptr_pending = 0; e_ovf = 1'b0;
    end else if (m_ptr_pending) begin
      m_ptr_pending = 0;
      if (m_lines < 256) begin
        len        = 10'(m_words - m_line_start - 1);
        e_ptr_we   = 1'b1;
        e_ptr_addr = 8'(m_lines);
        e_ptr_din  = {len, 10'(m_line_start)};
        m_lines++;
        m_line_start = m_words;
      end else begin
        m_full = 1; e_ovf = 1'b1;
      end
    end else if (in_valid && !m_full) begin
      m_pend.push_back(in_data);
      if (m_pend.size() == 2 || in_last) begin
        word = (m_pend.size() == 2) ? {m_pend[0], m_pend[1]} : {m_pend[0], PAD};
        m_pend.delete();
        if (m_words < 1024) begin
          e_mem_we   = 1'b1;
          e_mem_addr = 10'(m_words);
          e_mem_din  = word;
          m_words++;
          m_ptr_pending = in_last;
        end else begin
          m_full = 1; e_ovf = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare plus logs of what the DUT actually wrote.
  bit          chk_en = 0;
  logic [15:0] dut_mem[1024];
  logic [19:0] dut_ptr[256];
  int          mem_cnt = 0, ptr_cnt = 0, notready_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk(32'(mem_we), 32'(e_mem_we), "mem_we");
      if (e_mem_we && mem_we === 1'b1) begin
        chk(32'(mem_addr), 32'(e_mem_addr), "mem_addr");
        chk(32'(mem_din), 32'(e_mem_din), "mem_din");
      end
      chk(32'(ptr_we), 32'(e_ptr_we), "ptr_we");
      if (e_ptr_we && ptr_we === 1'b1) begin
        chk(32'(ptr_addr), 32'(e_ptr_addr), "ptr_addr");
        chk(32'(ptr_din), 32'(e_ptr_din), "ptr_din");
      end
      chk(32'(lines_loaded), 32'(m_lines), "lines_loaded");
      chk(32'(overflow), 32'(e_ovf), "overflow");
      chk(32'(in_ready), 32'(!m_ptr_pending && !rst && !clear), "in_ready");
      if (mem_we === 1'b1) begin dut_mem[mem_addr] = mem_din; mem_cnt++; end
      if (ptr_we === 1'b1) begin dut_ptr[ptr_addr] = ptr_din; ptr_cnt++; end
      if (in_ready === 1'b0 && !rst && !clear) notready_cnt++;
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = b; in_last = last;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    if (in_ready !== 1'b1) chk(32'(in_ready), 32'd1, "ready_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_clear();
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0, p0, r0, len;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk(32'(mem_we), 32'd0, "rst_mem_we");
    chk(32'(mem_addr), 32'd0, "rst_mem_addr");
    chk(32'(ptr_din), 32'd0, "rst_ptr_din");
    chk(32'(lines_loaded), 32'd0, "rst_lines");
    chk(32'(in_ready), 32'd0, "rst_in_ready");
    @(posedge clk); #1;
    rst = 1'b0;

    // "Hi" straight after reset
    r0 = notready_cnt;
    send_byte("H", 1'b0);
    send_byte("i", 1'b1);
    idle(3);
    chk(32'(dut_mem[0]), 32'h4869, "hi_word");
    chk(32'(dut_ptr[0]), 32'h00000, "hi_ptr");
    chk(32'(lines_loaded), 32'd1, "hi_lines");
    chk(32'(mem_cnt), 32'd1, "hi_mem_cnt");
    chk(32'(notready_cnt - r0), 32'd1, "hi_stall_cycles");

    // "abc" then "de"
    pulse_clear();
    p0 = ptr_cnt;
    send_byte("a", 1'b0); send_byte("b", 1'b0); send_byte("c", 1'b1);
    send_byte("d", 1'b0); send_byte("e", 1'b1);
    idle(3);
    chk(32'(dut_mem[0]), 32'h6162, "abc_w0");
    chk(32'(dut_mem[1]), 32'h6320, "abc_w1_pad");
    chk(32'(dut_mem[2]), 32'h6465, "de_w2");
    chk(32'(dut_ptr[0]), {12'd0, 10'd1, 10'd0}, "abc_ptr");
    chk(32'(dut_ptr[1]), {12'd0, 10'd0, 10'd2}, "de_ptr");
    chk(32'(ptr_cnt - p0), 32'd2, "abcde_ptr_cnt");

    // 6-byte line with in_valid toggled randomly
    pulse_clear();
    m0 = mem_cnt;
    begin
      logic [7:0] s[6] = '{"q", "w", "e", "r", "t", "y"};
      for (int i = 0; i < 6; i++) begin
        idle($urandom_range(0, 3));
        send_byte(s[i], 1'(i == 5));
      end
    end
    idle(3);
    chk(32'(dut_mem[0]), 32'h7177, "tog_w0");
    chk(32'(dut_mem[1]), 32'h6572, "tog_w1");
    chk(32'(dut_mem[2]), 32'h7479, "tog_w2");
    chk(32'(mem_cnt - m0), 32'd3, "tog_mem_cnt");

    // clear after 3 bytes, then "XY"
    pulse_clear();
    send_byte("1", 1'b0); send_byte("2", 1'b0); send_byte("3", 1'b0);
    pulse_clear();
    m0 = mem_cnt;
    send_byte("X", 1'b0); send_byte("Y", 1'b1);
    idle(3);
    chk(32'(dut_mem[0]), 32'h5859, "clr_word");
    chk(32'(dut_ptr[0]), 32'h00000, "clr_ptr");
    chk(32'(overflow), 32'd0, "clr_ovf");
    chk(32'(mem_cnt - m0), 32'd1, "clr_mem_cnt");

    // random lines with gaps and occasional clear/reset
    for (int l = 0; l < 40; l++) begin
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if ($urandom_range(0, 40) == 0) pulse_clear();
        send_byte(8'($urandom_range(33, 126)), 1'(i == len - 1));
      end
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1; idle(1); rst = 1'b0;
      end
    end
    idle(3);

    // memory exhaustion: 1025 pairs as one line
    pulse_clear();
    m0 = mem_cnt; p0 = ptr_cnt;
    for (int i = 0; i < 2050; i++) send_byte(8'($urandom_range(33, 126)), 1'(i == 2049));
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'($urandom));
    idle(3);
    chk(32'(mem_cnt - m0), 32'd1024, "mfull_mem_cnt");
    chk(32'(ptr_cnt - p0), 32'd0, "mfull_ptr_cnt");
    chk(32'(overflow), 32'd1, "mfull_ovf");
    chk(32'(in_ready), 32'd1, "mfull_ready");

    // table exhaustion: 257 two-byte lines
    pulse_clear();
    m0 = mem_cnt; p0 = ptr_cnt;
    for (int i = 0; i < 257; i++) begin
      send_byte("L", 1'b0);
      send_byte(8'(i), 1'b1);
    end
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'($urandom));
    idle(3);
    chk(32'(mem_cnt - m0), 32'd257, "tfull_mem_cnt");
    chk(32'(ptr_cnt - p0), 32'd256, "tfull_ptr_cnt");
    chk(32'(dut_ptr[255]), {12'd0, 10'd0, 10'd255}, "tfull_ptr255");
    chk(32'(lines_loaded), 32'd256, "tfull_lines");
    chk(32'(overflow), 32'd1, "tfull_ovf");

    // reset mid-line
    send_byte("z", 1'b0);
    rst = 1'b1; idle(1); rst = 1'b0;
    idle(2);
    chk(32'(lines_loaded), 32'd0, "rst2_lines");
    chk(32'(overflow), 32'd0, "rst2_ovf");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
